psram_rd_pack: RTL
==================

PSRAM_RD_PACK -- requirements
Module: psram_rd_pack

Interface
REQ-001 SHALL have parameter: DEPTH, 16, packed-word storage depth in 32-bit words (power of 2, >=4).
REQ-002 SHALL have parameter: PROG_EMPTY_TH, 4, prog_empty threshold in words.
REQ-003 SHALL have port: clk  input  1  single clock for all logic.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: wdata  input  16  halfword read back from pSRAM.
REQ-006 SHALL have port: wen  input  1  wdata valid this cycle.
REQ-007 SHALL have port: sync  input  1  qualifies wdata as the low half of a word (realign); used only with wen.
REQ-008 SHALL have port: wfull  output  1  storage full; halfwords not accepted.
REQ-009 SHALL have port: rdata  output  32  packed word to the video side.
REQ-010 SHALL have port: ren  input  1  read request.
REQ-011 SHALL have port: rempty  output  1  no stored words.
REQ-012 SHALL have port: prog_empty  output  1  stored words <= PROG_EMPTY_TH.
REQ-013 SHALL have port: level  output  $clog2(DEPTH)+1  stored word count.
REQ-014 SHALL have port: err  output  3  sticky flags {align_err, underflow, overflow}.

Function
REQ-015 SHALL pack halfwords in arrival order: first halfword -> rdata[15:0], second -> rdata[31:16].
REQ-016 SHALL map bytes as: rdata[7:0]=first[7:0], rdata[15:8]=first[15:8], rdata[23:16]=second[7:0], rdata[31:24]=second[15:8].
REQ-017 SHALL keep a half_sel state bit: LOW (expect low half) and HIGH (low half held in pack register).
REQ-018 SHALL, on accepted halfword (wen & !wfull) in LOW, latch wdata into the pack register and go to HIGH.
REQ-019 SHALL, on accepted halfword in HIGH without sync, write {wdata, pack register} to storage and go to LOW; level rises by 1 the next cycle.
REQ-020 SHALL, on accepted halfword with sync=1 in HIGH, discard the held low half, latch wdata as new low half, stay HIGH, and set align_err.
REQ-021 SHALL treat sync=1 in LOW as a normal low half (no error).
REQ-022 SHALL assert wfull when level==DEPTH, regardless of half_sel.
REQ-023 SHALL drop a halfword with wen=1 and wfull=1, leave half_sel and the pack register unchanged, and set overflow.
REQ-024 SHALL, on ren & !rempty, pop the oldest word; rdata SHALL present it on the next cycle (1-cycle latency) and hold it until the next successful pop.
REQ-025 SHALL ignore ren when rempty=1, keep rdata unchanged, and set underflow.
REQ-026 SHALL leave level unchanged on a same-cycle word write and pop; both SHALL take effect.
REQ-027 SHALL NOT allow a pop of the word written in the same cycle when level==0 (rempty holds for that cycle).
REQ-028 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated words.
REQ-029 SHALL derive rempty=(level==0) and prog_empty=(level<=PROG_EMPTY_TH), both registered with level.
REQ-030 SHALL keep err bits set until reset; no other clear mechanism.

Reset
REQ-031 SHALL, while reset=1, asynchronously force: level=0, pointers=0, half_sel=LOW, pack register=0, rdata=0, rempty=1, prog_empty=1, wfull=0, err=0.
REQ-032 SHALL discard any stored words and a held low half when reset asserts mid-operation; the first halfword after release is a low half.
REQ-033 SHALL resume normal operation on the first clk edge after reset deasserts.

Verification
REQ-034 SHALL cover: wen halfwords 0x1111,0x2222,0x3333,0x4444 then ren x2 -> rdata 0x22221111 then 0x44443333, level 2->0, rempty=1.
REQ-035 SHALL cover: 2*DEPTH+1 halfwords with no reads -> wfull=1 at level=16, the extra halfword dropped, err=3'b001; after one ren, wfull=0.
REQ-036 SHALL cover: 0xAAAA, then 0xBBBB with sync=1, then 0xCCCC -> one word 0xCCCCBBBB stored, err[2]=1.
REQ-037 SHALL cover: ren with level=0 -> rdata unchanged, err[1]=1; at level=4 prog_empty=1, at level=5 prog_empty=0.
REQ-038 SHALL cover: continuous write and read across 40 words (pointer wrap), including a same-cycle write+pop -> data in order, level stable.
REQ-039 SHALL cover: reset asserted with level=3 and a held low half -> all outputs at reset values immediately; next pair 0x0001,0x0002 reads as 0x00020001.

Source files
------------

// File: rtl/psram_rd_pack.sv
// Packs pSRAM read-back halfwords into 32-bit words and buffers them for the video side.
// The first halfword of a pair is the low half; sync realigns a pair that was cut short.
module psram_rd_pack #(
  parameter int DEPTH         = 16,
  parameter int PROG_EMPTY_TH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              wdata,
  input  logic                     wen,
  input  logic                     sync,
  output logic                     wfull,
  output logic [31:0]              rdata,
  input  logic                     ren,
  output logic                     rempty,
  output logic                     prog_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [2:0]               err,
  output logic                     dbg_half_sel
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] PE_TH    = LW'(PROG_EMPTY_TH);

  // Handshake: a halfword is taken on any clk edge with wen=1 and wfull=0;
  // a word is popped on any clk edge with ren=1 and rempty=0, and appears
  // on rdata one cycle later, held until the next pop.

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } half_sel_e;

  half_sel_e        half_sel_q, half_sel_d;
  logic [15:0]      pack_q, pack_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             rempty_q, rempty_d;
  logic             prog_empty_q, prog_empty_d;
  logic             wfull_q, wfull_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       err_q, err_d;
  logic [31:0]      mem [DEPTH];

  logic accept;
  logic push;
  logic pop;

  always_comb begin
    accept       = wen & ~wfull_q;
    push         = accept & (half_sel_q == HIGH) & ~sync;
    // rempty_q is still set in the cycle a word first lands, so it cannot be popped yet.
    pop          = ren & ~rempty_q;

    half_sel_d   = half_sel_q;
    pack_d       = pack_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    if (accept) begin
      if (half_sel_q == LOW || sync) begin
        pack_d     = wdata;
        half_sel_d = HIGH;
        if (half_sel_q == HIGH) begin
          err_d[2] = 1'b1;
        end
      end else begin
        half_sel_d = LOW;
        wr_ptr_d   = wr_ptr_q + AW'(1);
      end
    end

    if (wen && wfull_q) begin
      err_d[0] = 1'b1;
    end
    if (ren && rempty_q) begin
      err_d[1] = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      rdata_d  = mem[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    rempty_d     = (level_d == '0);
    prog_empty_d = (level_d <= PE_TH);
    wfull_d      = (level_d == FULL_LVL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_sel_q   <= LOW;
      pack_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rempty_q     <= 1'b1;
      prog_empty_q <= 1'b1;
      wfull_q      <= 1'b0;
      rdata_q      <= '0;
      err_q        <= '0;
    end else begin
      half_sel_q   <= half_sel_d;
      pack_q       <= pack_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rempty_q     <= rempty_d;
      prog_empty_q <= prog_empty_d;
      wfull_q      <= wfull_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Storage contents are not reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {wdata, pack_q};
    end
  end

  assign wfull        = wfull_q;
  assign rdata        = rdata_q;
  assign rempty       = rempty_q;
  assign prog_empty   = prog_empty_q;
  assign level        = level_q;
  assign err          = err_q;
  assign dbg_half_sel = half_sel_q;

endmodule
